// File: rtl/pulse_train_pkg.sv
// Shared definitions for the pulse train generator.
//   - State encoding constants and the FSM state enum.
//   - MIN_DUR: smallest phase length in cycles; a requested duration of 0 is raised to this.
package pulse_train_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int unsigned MIN_DUR = 1;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StHigh = ST_HIGH,
    StLow  = ST_LOW,
    StDone = ST_DONE
  } state_e;

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter shared by the high and low phases of the pulse train.
// Ports:
//   clk      - rising-edge clock
//   reset    - synchronous active-high reset, clears the count
//   load     - load load_val into the counter this edge (takes priority over counting)
//   load_val - phase length minus one
//   expire   - high while the count is zero, i.e. in the last cycle of the phase
module phase_timer #(
  parameter int unsigned DUR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  output logic             expire
);

  logic [DUR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DUR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Burst pulse generator: on an accepted start, emits num_pulses clean rising edges on signal,
// with programmable high and low widths (0 treated as 1). No trailing low phase: done is raised
// in the cycle signal first falls after the last pulse.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   start       - burst request, accepted only when not busy (IDLE or DONE)
//   num_pulses  - edge count, latched on accepted start
//   high_cycles - high-phase length, latched on accepted start
//   low_cycles  - low-phase length, latched on accepted start
//   signal      - registered pulse train
//   busy        - burst in progress
//   done        - one-cycle end-of-burst pulse
//   edges_sent  - rising edges emitted in the current/last burst
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned DUR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [DUR_W-1:0] high_cycles,
  input  logic [DUR_W-1:0] low_cycles,
  output logic             signal,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edges_sent
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [DUR_W-1:0] h_q, h_d;
  logic [DUR_W-1:0] l_q, l_d;
  logic [CNT_W-1:0] edges_q, edges_d;
  logic             signal_q, signal_d;

  logic             tmr_load;
  logic [DUR_W-1:0] tmr_load_val;
  logic             tmr_expire;
  logic [DUR_W-1:0] high_clamp, low_clamp;

  assign high_clamp = (high_cycles == '0) ? DUR_W'(MIN_DUR) : high_cycles;
  assign low_clamp  = (low_cycles == '0) ? DUR_W'(MIN_DUR) : low_cycles;

  phase_timer #(
    .DUR_W(DUR_W)
  ) u_phase_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_load_val),
    .expire  (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    h_d          = h_q;
    l_d          = l_q;
    edges_d      = edges_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          n_d     = num_pulses;
          h_d     = high_clamp;
          l_d     = low_clamp;
          edges_d = '0;
          if (num_pulses != '0) begin
            // First edge is emitted on the accepting edge itself.
            state_d      = StHigh;
            edges_d      = CNT_W'(1);
            tmr_load     = 1'b1;
            tmr_load_val = high_clamp - DUR_W'(1);
          end else begin
            state_d = StDone;
          end
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end
      StHigh: begin
        if (tmr_expire) begin
          if (edges_q == n_q) begin
            state_d = StDone;
          end else begin
            state_d      = StLow;
            tmr_load     = 1'b1;
            tmr_load_val = l_q - DUR_W'(1);
          end
        end
      end
      StLow: begin
        if (tmr_expire) begin
          state_d      = StHigh;
          edges_d      = edges_q + CNT_W'(1);
          tmr_load     = 1'b1;
          tmr_load_val = h_q - DUR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    signal_d = (state_d == StHigh);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      n_q      <= '0;
      h_q      <= DUR_W'(MIN_DUR);
      l_q      <= DUR_W'(MIN_DUR);
      edges_q  <= '0;
      signal_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      h_q      <= h_d;
      l_q      <= l_d;
      edges_q  <= edges_d;
      signal_q <= signal_d;
    end
  end

  assign signal     = signal_q;
  assign busy       = (state_q == StHigh) || (state_q == StLow);
  assign done       = (state_q == StDone);
  assign edges_sent = edges_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] num_pulses;
  logic [7:0] high_cycles;
  logic [7:0] low_cycles;
  logic       signal;
  logic       busy;
  logic       done;
  logic [3:0] edges_sent;

  always #5 clk = ~clk;

  pulse_train_gen #(
    .CNT_W(4),
    .DUR_W(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_pulses (num_pulses),
    .high_cycles(high_cycles),
    .low_cycles (low_cycles),
    .signal     (signal),
    .busy       (busy),
    .done       (done),
    .edges_sent (edges_sent)
  );

  // Inputs applied for one edge, outputs expected just after that edge.
  typedef struct {
    logic       rst;
    logic       st;
    logic [3:0] n;
    logic [7:0] h;
    logic [7:0] l;
    logic       e_sig;
    logic       e_busy;
    logic       e_done;
    logic [3:0] e_edges;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic void add(input logic rst, input logic st, input logic [3:0] n,
                              input logic [7:0] h, input logic [7:0] l, input logic es,
                              input logic eb, input logic ed, input logic [3:0] ee);
    vec_t v;
    v.rst = rst; v.st = st; v.n = n; v.h = h; v.l = l;
    v.e_sig = es; v.e_busy = eb; v.e_done = ed; v.e_edges = ee;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [3:0] n, input logic [7:0] h,
                       input logic [7:0] l);
    start = st; num_pulses = n; high_cycles = h; low_cycles = l;
  endtask

  initial begin
    int det_edges;
    int busy_cyc;
    logic prev_sig;
    logic seen;

    reset = 1'b1;
    drive(1'b0, 4'd0, 8'd0, 8'd0);

    // Reset held 5 cycles.
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // N=3 H=1 L=1: 1,0,1,0,1 then done.
    add(0, 1, 3, 1, 1, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 1, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 1, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 3);
    // N=2 H=3 L=2, inputs scrambled while busy must not matter.
    add(0, 1, 2, 3, 2, 1, 1, 0, 1);
    add(0, 0, 9, 0, 7, 1, 1, 0, 1);
    add(0, 0, 9, 0, 7, 1, 1, 0, 1);
    add(0, 0, 9, 0, 7, 0, 1, 0, 1);
    add(0, 0, 9, 0, 7, 0, 1, 0, 1);
    add(0, 0, 9, 0, 7, 1, 1, 0, 2);
    add(0, 0, 9, 0, 7, 1, 1, 0, 2);
    add(0, 0, 9, 0, 7, 1, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 2);
    // N=0: immediate done, no edges.
    add(0, 1, 0, 5, 5, 0, 0, 1, 0);
    add(0, 0, 0, 5, 5, 0, 0, 0, 0);
    // H=0 L=0 N=2 behaves as H=L=1.
    add(0, 1, 2, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 2);
    // N=4 H=2 L=2, retrigger (N=1) at cycle 3 ignored; start on done relaunches.
    add(0, 1, 4, 2, 2, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 1, 1, 1, 1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 2);
    add(0, 0, 0, 0, 0, 1, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 1, 1, 0, 3);
    add(0, 0, 0, 0, 0, 1, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 1, 0, 3);
    add(0, 0, 0, 0, 0, 1, 1, 0, 4);
    add(0, 0, 0, 0, 0, 1, 1, 0, 4);
    add(0, 0, 0, 0, 0, 0, 0, 1, 4);
    add(0, 1, 1, 1, 1, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // N=5 H=2 L=1, reset during 2nd HIGH: no done, then a fresh burst works.
    add(0, 1, 5, 2, 1, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 2);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 1, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      drive(vecs[i].st, vecs[i].n, vecs[i].h, vecs[i].l);
      tick();
      chk($sformatf("v%0d signal", i), 32'(signal), 32'(vecs[i].e_sig));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].e_done));
      chk($sformatf("v%0d edges_sent", i), 32'(edges_sent), 32'(vecs[i].e_edges));
    end

    // Three-edge detector model watching signal during an N=3 H=1 L=1 burst.
    reset = 1'b0;
    drive(1'b1, 4'd3, 8'd1, 8'd1);
    tick();
    drive(1'b0, 4'd0, 8'd0, 8'd0);
    det_edges = 0;
    busy_cyc = 0;
    prev_sig = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (signal && !prev_sig) det_edges++;
      prev_sig = signal;
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("det done_seen", 32'(seen), 32'd1);
    chk("det flag", 32'(det_edges >= 3), 32'd1);
    chk("det edge_count", 32'(det_edges), 32'd3);
    chk("det busy_cycles", 32'(busy_cyc), 32'd5);
    chk("det signal_at_done", 32'(signal), 32'd0);
    chk("det edges_sent", 32'(edges_sent), 32'd3);

    // Start coincident with done from an N=1 H=2 burst.
    tick();
    drive(1'b1, 4'd1, 8'd2, 8'd1);
    tick();
    drive(1'b0, 4'd0, 8'd0, 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("coinc first_done", 32'(seen), 32'd1);
    drive(1'b1, 4'd2, 8'd1, 8'd1);
    tick();
    drive(1'b0, 4'd0, 8'd0, 8'd0);
    chk("coinc relaunch_signal", 32'(signal), 32'd1);
    chk("coinc relaunch_done", 32'(done), 32'd0);
    chk("coinc relaunch_edges", 32'(edges_sent), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("coinc second_done", 32'(seen), 32'd1);
    chk("coinc final_edges", 32'(edges_sent), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
